// File: rtl/fwpit_pkg.sv
// fwpit_pkg: register map and VECTOR field layout shared by the interrupt controller.
package fwpit_pkg;
  localparam logic [2:0] ADR_RAW    = 3'd0;
  localparam logic [2:0] ADR_ENABLE = 3'd1;
  localparam logic [2:0] ADR_ACTIVE = 3'd2;
  localparam logic [2:0] ADR_CLEAR  = 3'd3;
  localparam logic [2:0] ADR_MODE   = 3'd4;
  localparam logic [2:0] ADR_VECTOR = 3'd5;
  localparam logic [2:0] ADR_SET    = 3'd6;
  localparam int VEC_VALID = 31;
  localparam int VEC_IDX_W = 5;
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/fwpit_irqc_prienc.sv
// fwpit_irqc_prienc: lowest-index-wins priority encoder.
module fwpit_irqc_prienc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = 5'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/fwpit_irqc.sv
// fwpit_irqc: Wishbone-mapped interrupt controller with per-source edge/level latching.
module fwpit_irqc
  import fwpit_pkg::*;
#(
  parameter int               N_IRQ        = 8,
  parameter logic [N_IRQ-1:0] RESET_ENABLE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       rt_adr,
  input  logic [31:0]      rt_dat_w,
  output logic [31:0]      rt_dat_r,
  input  logic             rt_cyc,
  input  logic             rt_stb,
  input  logic             rt_we,
  input  logic [3:0]       rt_sel,
  output logic             rt_ack,
  output logic             rt_err,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o
);
  // Registers are kept 32 bits wide; bits at or above N_IRQ are forced to 0 by msk.
  localparam logic [31:0] MSK = 32'((64'd1 << N_IRQ) - 64'd1);
  logic [31:0] raw, enable, mode, active, wm, wd, clr, set, hw, irq_w, prev_w, rd, vec;
  logic [N_IRQ-1:0] prev;
  logic req, wr, vld;
  logic [4:0] idx;
  assign rt_err = 1'b0;
  assign req    = rt_cyc & rt_stb & ~rt_ack;
  assign wr     = req & rt_we;
  assign wm     = byte_mask(rt_sel);
  assign wd     = rt_dat_w & wm & MSK;
  assign clr    = (wr && rt_adr == ADR_CLEAR) ? wd : '0;
  assign set    = (wr && rt_adr == ADR_SET) ? wd : '0;
  assign irq_w  = 32'(irq_i);
  assign prev_w = 32'(prev);
  // Level sources set every cycle they are high; edge sources only on 0->1.
  assign hw     = irq_w & (~mode | ~prev_w);
  assign active = raw & enable;
  fwpit_irqc_prienc #(.N(N_IRQ)) u_prienc (
    .req(active[N_IRQ-1:0]),
    .valid(vld),
    .idx(idx)
  );
  always_comb begin
    vec = '0;
    vec[VEC_VALID] = vld;
    vec[VEC_IDX_W-1:0] = idx;
    rd = '0;
    case (rt_adr)
      ADR_RAW:    rd = raw;
      ADR_ENABLE: rd = enable;
      ADR_ACTIVE: rd = active;
      ADR_MODE:   rd = mode;
      ADR_VECTOR: rd = vec;
      default:    rd = '0;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw      <= '0;
      enable   <= 32'(RESET_ENABLE);
      mode     <= '0;
      prev     <= '0;
      rt_ack   <= 1'b0;
      rt_dat_r <= '0;
      irq_o    <= 1'b0;
    end else begin
      raw      <= (raw & ~clr) | hw | set;
      enable   <= (wr && rt_adr == ADR_ENABLE) ? (enable & ~wm) | wd : enable;
      mode     <= (wr && rt_adr == ADR_MODE) ? (mode & ~wm) | wd : mode;
      prev     <= irq_i;
      rt_ack   <= req;
      rt_dat_r <= req ? rd : '0;
      irq_o    <= |active;
    end
  end
endmodule

// File: tb/tb_fwpit_irqc.sv
// tb_fwpit_irqc: directed scenarios plus random traffic against a per-source behavioural model.
module tb_fwpit_irqc;
  localparam int N = 8;
  typedef struct {
    bit          chk;
    logic [31:0] d;
  } exp_t;
  logic clock = 0, reset = 1;
  logic [2:0] rt_adr = '0;
  logic [31:0] rt_dat_w = '0, rt_dat_r;
  logic rt_cyc = 0, rt_stb = 0, rt_we = 0, rt_ack, rt_err, irq_o;
  logic [3:0] rt_sel = '0;
  logic [N-1:0] irq_i = '0;
  int tests = 0, fails = 0;
  exp_t sbq[$];
  bit m_raw[N], m_en[N], m_mode[N], m_prev[N];
  bit m_ack, m_irq;

  fwpit_irqc #(.N_IRQ(N), .RESET_ENABLE('0)) dut (
    .clock(clock), .reset(reset), .rt_adr(rt_adr), .rt_dat_w(rt_dat_w), .rt_dat_r(rt_dat_r),
    .rt_cyc(rt_cyc), .rt_stb(rt_stb), .rt_we(rt_we), .rt_sel(rt_sel), .rt_ack(rt_ack),
    .rt_err(rt_err), .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] raw_v, en_v, mode_v, vec_v;
    int lo;
    raw_v = '0; en_v = '0; mode_v = '0; lo = -1;
    for (int i = 0; i < N; i++) begin
      raw_v[i] = m_raw[i];
      en_v[i] = m_en[i];
      mode_v[i] = m_mode[i];
    end
    for (int i = N - 1; i >= 0; i--) if (m_raw[i] && m_en[i]) lo = i;
    vec_v = (lo < 0) ? 32'h0 : (32'h8000_0000 | 32'(lo));
    case (a)
      3'd0: return raw_v;
      3'd1: return en_v;
      3'd2: return raw_v & en_v;
      3'd4: return mode_v;
      3'd5: return vec_v;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_raw[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
      end
      m_ack = 0;
      m_irq = 0;
      sbq.delete();
    end else begin
      bit req, any, wen, hw;
      req = rt_cyc && rt_stb && !m_ack;
      if (req) sbq.push_back('{chk: !rt_we, d: model_read(rt_adr)});
      any = 0;
      for (int i = 0; i < N; i++) any |= m_raw[i] && m_en[i];
      for (int i = 0; i < N; i++) begin
        wen = req && rt_we && rt_sel[i/8] && rt_dat_w[i];
        hw = m_mode[i] ? (irq_i[i] && !m_prev[i]) : irq_i[i];
        if (hw || (wen && rt_adr == 3'd6)) m_raw[i] = 1;
        else if (wen && rt_adr == 3'd3) m_raw[i] = 0;
        if (req && rt_we && rt_sel[i/8] && rt_adr == 3'd1) m_en[i] = rt_dat_w[i];
        if (req && rt_we && rt_sel[i/8] && rt_adr == 3'd4) m_mode[i] = rt_dat_w[i];
        m_prev[i] = irq_i[i];
      end
      m_ack = req;
      m_irq = any;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      chk("ack", 32'(rt_ack), 32'(m_ack));
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("err", 32'(rt_err), 0);
      if (rt_ack) begin
        if (sbq.size() == 0) chk("sb_depth", 32'(sbq.size()), 1);
        else begin
          e = sbq.pop_front();
          if (e.chk) chk("rd", rt_dat_r, e.d);
        end
      end else chk("dat_idle", rt_dat_r, 0);
    end
  end

  task automatic start(input logic [2:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
    rt_adr = a; rt_we = we; rt_dat_w = d; rt_sel = s; rt_cyc = 1; rt_stb = 1;
  endtask

  task automatic fin(output logic [31:0] r);
    @(negedge clock);
    chk("ack_lat", 32'(rt_ack), 1);
    r = rt_dat_r;
    rt_cyc = 0; rt_stb = 0; rt_we = 0;
  endtask

  task automatic bus(input logic [2:0] a, input logic we, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    @(negedge clock);
    start(a, we, d, s);
    fin(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    repeat (2) @(negedge clock);
    reset = 0;
    bus(3'd1, 0, 0, 4'hf, r); chk("r029_enable", r, 0); chk("r029_irq_o", 32'(irq_o), 0);
    bus(3'd1, 1, 32'h05, 4'hf, r);
    bus(3'd4, 1, 32'h01, 4'hf, r);
    @(negedge clock); irq_i[0] = 1;
    @(negedge clock); irq_i[0] = 0; chk("r030_irq_o_1cyc", 32'(irq_o), 0);
    @(negedge clock); chk("r030_irq_o_2cyc", 32'(irq_o), 1);
    bus(3'd0, 0, 0, 4'hf, r); chk("r030_raw", r, 32'h01);
    bus(3'd5, 0, 0, 4'hf, r); chk("r030_vector", r, 32'h8000_0000);
    bus(3'd3, 1, 32'h01, 4'hf, r);
    @(negedge clock); irq_i[2] = 1;
    bus(3'd3, 1, 32'h04, 4'hf, r);
    bus(3'd0, 0, 0, 4'hf, r); chk("r031_raw_held", r, 32'h04);
    @(negedge clock); irq_i[2] = 0;
    bus(3'd3, 1, 32'h04, 4'hf, r); chk("r031_irq_o_ack", 32'(irq_o), 1);
    @(negedge clock); chk("r031_irq_o_fall", 32'(irq_o), 0);
    bus(3'd0, 0, 0, 4'hf, r); chk("r031_raw_clr", r, 0);
    @(negedge clock); irq_i[0] = 1; start(3'd3, 1, 32'h01, 4'hf); fin(r);
    irq_i[0] = 0;
    bus(3'd0, 0, 0, 4'hf, r); chk("r032_raw", r, 32'h01);
    bus(3'd3, 1, 32'h01, 4'hf, r);
    bus(3'd1, 1, 32'hff, 4'h0, r);
    bus(3'd1, 0, 0, 4'hf, r); chk("sel_none_enable", r, 32'h05);
    bus(3'd1, 1, 32'h0C, 4'h1, r);
    bus(3'd6, 1, 32'h0C, 4'hf, r);
    bus(3'd2, 0, 0, 4'hf, r); chk("r033_active", r, 32'h0C);
    bus(3'd5, 0, 0, 4'hf, r); chk("r033_vector", r, 32'h8000_0002);
    chk("r033_irq_before", 32'(irq_o), 1);
    bus(3'd6, 1, 32'h80, 4'h1, r);
    bus(3'd0, 0, 0, 4'hf, r); chk("r033_raw7", r, 32'h8C); chk("r033_irq_after", 32'(irq_o), 1);
    bus(3'd4, 1, 32'h00, 4'hf, r);
    bus(3'd0, 0, 0, 4'hf, r); chk("mode_keeps_raw", r, 32'h8C);
    bus(3'd1, 1, 32'h00, 4'hf, r);
    @(negedge clock); chk("mask_irq_o", 32'(irq_o), 0);
    bus(3'd0, 0, 0, 4'hf, r); chk("mask_keeps_raw", r, 32'h8C);
    bus(3'd1, 1, 32'hFFFF_FF0A, 4'hf, r);
    bus(3'd1, 0, 0, 4'hf, r); chk("enable_hi_bits", r, 32'h0A);
    bus(3'd4, 1, 32'h03, 4'hf, r);
    @(negedge clock); start(3'd0, 0, 0, 4'hf);
    #2 reset = 1;
    @(negedge clock); rt_cyc = 0; rt_stb = 0;
    chk("r034_ack", 32'(rt_ack), 0); chk("r034_irq", 32'(irq_o), 0); chk("r034_dat", rt_dat_r, 0);
    @(negedge clock); reset = 0;
    @(negedge clock); chk("r034_no_ack", 32'(rt_ack), 0);
    bus(3'd0, 0, 0, 4'hf, r); chk("r034_raw", r, 0);
    bus(3'd1, 0, 0, 4'hf, r); chk("r034_enable", r, 0);
    bus(3'd4, 0, 0, 4'hf, r); chk("r034_mode", r, 0);
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if ($urandom_range(3) == 0) irq_i = N'($urandom);
      if ($urandom_range(1) == 1) bus(3'($urandom), 1'($urandom), $urandom, 4'($urandom), r);
    end
    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fwpit_irqc.md
FWPIT_IRQC -- requirements
Module: fwpit_irqc

Interface
REQ-001 Parameter: N_IRQ, 8, number of interrupt sources (1..32).
REQ-002 Parameter: RESET_ENABLE, 0, reset value of ENABLE register (N_IRQ bits).
REQ-003 Port: clock  in  1  single clock for all logic.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: rt_adr  in  3  Wishbone target word address.
REQ-006 Port: rt_dat_w  in  32  write data; rt_dat_r  out  32  read data.
REQ-007 Port: rt_cyc, rt_stb, rt_we  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-008 Port: rt_sel  in  4  byte selects; rt_ack  out  1; rt_err  out  1, tied 0.
REQ-009 Port: irq_i  in  N_IRQ  source requests, synchronous to clock (e.g. pit irq outputs).
REQ-010 Port: irq_o  out  1  aggregated interrupt to the CPU.

Function
REQ-011 Register map (word address): 0 RAW (RO, latched pending), 1 ENABLE (RW), 2 ACTIVE (RO, RAW & ENABLE), 3 CLEAR (W1C on RAW), 4 MODE (RW, 1=edge, 0=level), 5 VECTOR (RO), 6 SET (W1S on RAW), 7 reserved (reads 0, writes ignored).
REQ-012 Bits at index >= N_IRQ shall read 0 and ignore writes in every register.
REQ-013 Access: rt_ack asserts exactly one cycle after a cycle with rt_cyc & rt_stb & !rt_ack, for one cycle; never two consecutive cycles.
REQ-014 Writes take effect on the ack cycle edge, honouring rt_sel per byte for ENABLE, MODE, CLEAR, SET.
REQ-015 rt_dat_r is registered, valid while rt_ack is high, 0 otherwise.
REQ-016 Edge mode: RAW[i] sets on the cycle after irq_i[i] goes 0->1 (registered previous value, reset 0).
REQ-017 Level mode: RAW[i] sets every cycle irq_i[i] is 1; CLEAR is ineffective while irq_i[i] remains 1.
REQ-018 RAW[i] holds until cleared by CLEAR write; set by hardware or SET in the same cycle as CLEAR wins (no event lost).
REQ-019 VECTOR: bit 31 = |ACTIVE; bits 4:0 = lowest index i with ACTIVE[i]=1, 0 when none.
REQ-020 irq_o is registered: irq_o = |(RAW & ENABLE) of previous cycle; latency from irq_i edge to irq_o = 2 cycles.
REQ-021 Changing MODE does not alter RAW; disabling a source masks irq_o without clearing RAW.
REQ-022 Reads of RAW, ACTIVE, VECTOR return values as of the request cycle (before that cycle's updates).

Reset
REQ-023 On reset asserted: RAW=0, MODE=0, ENABLE=RESET_ENABLE, edge history=0, rt_ack=0, rt_dat_r=0, irq_o=0, immediately and asynchronously.
REQ-024 A Wishbone access in flight at reset is dropped; no ack is issued for it after reset releases.
REQ-025 First edge detection after reset uses history 0, so irq_i high at release counts as an edge.

Structure
REQ-026 Register address constants (RAW..SET) and VECTOR field positions live in a shared package fwpit_pkg.
REQ-027 One sub-module fwpit_irqc_prienc: combinational lowest-index priority encoder, N_IRQ in, valid + 5-bit index out.
REQ-028 All state in one clocked process family using the asynchronous reset; no latches.

Verification
REQ-029 Reset, read addr 1 with RESET_ENABLE=0 -> rt_ack one cycle after stb, rt_dat_r=0x0, irq_o=0.
REQ-030 ENABLE=0x05, MODE=0x01, pulse irq_i[0] one cycle -> RAW=0x01, irq_o high 2 cycles after pulse, VECTOR=0x80000000.
REQ-031 Level source irq_i[2] held high, write CLEAR=0x04 -> RAW[2] stays 1; drop irq_i[2], CLEAR again -> RAW=0, irq_o falls next cycle.
REQ-032 Edge on irq_i[0] same cycle as CLEAR=0x01 write -> RAW[0]=1 afterwards.
REQ-033 ACTIVE=0x0C -> VECTOR=0x80000002; write SET=0x80 with ENABLE=0 bit7 -> RAW bit7 set, irq_o unchanged.
REQ-034 Assert reset while rt_stb high before ack -> no rt_ack, all registers at reset values, irq_o=0.
